// File: rtl/fpu_addsub_issue.sv
// fpu_addsub_issue: request FIFO + response register in front of one
// combinational bfloat16 Add_Sub unit, with an optional running-sum
// accumulator compiled in when FPU_ACC_EN is defined.
// Add_Sub (bf16 add/sub, round-to-nearest-even, canonical NaN 0x7FC0) is
// included below so this file builds on its own.

module Add_Sub (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        inst_i,   // 1 = add, 0 = sub
    output logic [15:0] result_o
);
    logic       s_a, s_b, a_nan, b_nan, a_inf, b_inf, a_big, s_big, s_small, rnd;
    logic [7:0] e_a, e_b, x_a, x_b, m_a, m_b, e_big, e_small, m_big, m_small, d;
    logic [17:0] sh;
    logic [10:0] aligned, norm;
    logic [11:0] sum;
    logic [3:0]  msb;
    logic [9:0]  lz, lim, sh_l, e_r;
    logic [8:0]  mant;

    // Align, add/subtract, normalise and round; specials override at the end.
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        s_a   = a_i[15];
        s_b   = b_i[15] ^ ~inst_i;
        e_a   = a_i[14:7];
        e_b   = b_i[14:7];
        a_nan = (&e_a) && (|a_i[6:0]);
        b_nan = (&e_b) && (|b_i[6:0]);
        a_inf = (&e_a) && !(|a_i[6:0]);
        b_inf = (&e_b) && !(|b_i[6:0]);
        m_a   = {|e_a, a_i[6:0]};
        m_b   = {|e_b, b_i[6:0]};
        x_a   = (e_a == 8'd0) ? 8'd1 : e_a;
        x_b   = (e_b == 8'd0) ? 8'd1 : e_b;
        a_big = {x_a, m_a} >= {x_b, m_b};
        e_big   = a_big ? x_a : x_b;
        m_big   = a_big ? m_a : m_b;
        s_big   = a_big ? s_a : s_b;
        e_small = a_big ? x_b : x_a;
        m_small = a_big ? m_b : m_a;
        s_small = a_big ? s_b : s_a;
        d       = e_big - e_small;
        sh      = {m_small, 10'b0} >> d;
        aligned = (d > 8'd17) ? {10'b0, |m_small} : {sh[17:8], sh[7] | (|sh[6:0])};
        sum = (s_big == s_small) ? ({1'b0, m_big, 3'b000} + {1'b0, aligned})
                                 : ({1'b0, m_big, 3'b000} - {1'b0, aligned});
        msb = '0;
        for (int i = 0; i < 11; i++) begin
            if (sum[i]) msb = 4'(i);
        end
        lz   = 10'd10 - {6'b0, msb};
        lim  = {2'b0, e_big} - 10'd1;
        sh_l = (lz > lim) ? lim : lz;
        if (sum[11]) begin
            norm = {sum[11:2], sum[1] | sum[0]};
            e_r  = {2'b0, e_big} + 10'd1;
        end else begin
            norm = sum[10:0] << sh_l;
            e_r  = norm[10] ? ({2'b0, e_big} - sh_l) : 10'd0;
        end
        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[10:3]} + {8'b0, rnd};
        if (mant[8]) begin
            mant = {1'b0, mant[8:1]};
            e_r  = e_r + 10'd1;
        end else if ((e_r == 10'd0) && mant[7]) begin
            e_r = 10'd1;
        end
        if (e_r >= 10'd255) result_o = {s_big, 8'hFF, 7'h00};
        else                result_o = {s_big, e_r[7:0], mant[6:0]};
        if (sum == 12'd0) result_o = {s_a & s_b, 15'b0};
        if (a_nan || b_nan || (a_inf && b_inf && (s_a != s_b))) result_o = 16'h7FC0;
        else if (a_inf) result_o = {s_a, 8'hFF, 7'h00};
        else if (b_inf) result_o = {s_b, 8'hFF, 7'h00};
    end
endmodule

module fpu_addsub_issue #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [15:0]      req_a_i,
    input  logic [15:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [15:0]      acc_o,
    output logic             busy_o
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]       op;
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [15:0]        acc_q, acc_d;
    logic               push, pop;
    logic [15:0]        add_a, add_res;

    assign head        = mem_q[rd_ptr_q];
    assign req_ready_o = (count_q != FULL_CNT);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (count_q != '0) && (!rsp_valid_q || rsp_ready_i);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign busy_o       = (count_q != '0) || rsp_valid_q;

`ifdef FPU_ACC_EN
    assign add_a = (head.op == 2'b10) ? acc_q : head.a;
    assign acc_o = acc_q;
`else
    logic unused_op1;
    assign unused_op1 = head.op[1];
    assign add_a      = head.a;
    assign acc_o      = 16'h0000;
`endif

    Add_Sub u_add_sub (
        .a_i      (add_a),
        .b_i      (head.b),
        .inst_i   (!head.op[0]),
        .result_o (add_res)
    );

    // FIFO bookkeeping, response slot and accumulator next-state.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        acc_d        = acc_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            rsp_valid_d  = 1'b1;
            rsp_result_d = add_res;
            rsp_tag_d    = head.tag;
`ifdef FPU_ACC_EN
            if (head.op == 2'b11) begin
                rsp_result_d = acc_q;
                acc_d        = 16'h0000;
            end else if (head.op == 2'b10) begin
                acc_d = add_res;
            end
`endif
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Control and response state, cleared by reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'h0000;
            rsp_tag_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // FIFO payload storage.
    // NOTE: the payload array has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef FPU_ACC_EN
    // Running-sum accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) acc_q <= 16'h0000;
        else         acc_q <= acc_d;
    end
`else
    assign acc_q = 16'h0000;
`endif
endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Directed bench for fpu_addsub_issue; expected bf16 results are hand-computed.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_fpu_addsub_issue;
    logic        clk, rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]  req_op;
    logic [15:0] req_a, req_b, rsp_result, acc;
    logic [3:0]  req_tag, rsp_tag;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          rsp_count = 0;
    bit          rnd_en = 0;
    logic [15:0] b_tbl [6] = '{16'h3F80, 16'h4000, 16'h4040, 16'h0000, 16'hBF80, 16'h3F00};
    logic [15:0] r_tbl [6] = '{16'h4000, 16'h4040, 16'h4080, 16'h3F80, 16'h0000, 16'h3FC0};

    fpu_addsub_issue #(.FIFO_DEPTH(2), .TAG_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_tag_i    (req_tag),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_tag_o    (rsp_tag),
        .acc_o        (acc),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboard: every response handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_tag", {28'b0, rsp_tag}, {28'b0, e.tag});
                check("rsp_result", {16'b0, rsp_result}, {16'b0, e.res});
            end
            rsp_count++;
        end
    end

    // Random response backpressure for the streaming phase.
    always @(posedge clk) begin
        #1;
        if (rnd_en) rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic drive_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] tag, input logic [15:0] res);
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        e.res     = res;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic wait_accept(input string name);
        int n  = 0;
        bit ok = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            else n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({"accept_", name}, {31'b0, ok}, 32'd1);
    endtask

    task automatic send(input string name, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag, input logic [15:0] res);
        drive_req(op, a, b, tag, res);
        wait_accept(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({"idle_", name}, {31'b0, (!busy && sb.size() == 0)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"},  {31'b0, req_ready},  32'd1);
        check({name, "_rsp_valid"},  {31'b0, rsp_valid},  32'd0);
        check({name, "_rsp_result"}, {16'b0, rsp_result}, 32'h0);
        check({name, "_rsp_tag"},    {28'b0, rsp_tag},    32'h0);
        check({name, "_acc"},        {16'b0, acc},        32'h0);
        check({name, "_busy"},       {31'b0, busy},       32'd0);
    endtask

    initial begin
        bit acc4;
        int base;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        // Single add: 1.0 + 2.0 = 3.0, one-cycle latency, then idle.
        send("add", 2'b00, 16'h3F80, 16'h4000, 4'd5, 16'h4040);
        @(negedge clk);
        check("lat_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
        check("lat_busy",       {31'b0, busy},      32'd1);
        @(negedge clk);
        check("lat_rsp_valid",  {31'b0, rsp_valid}, 32'd1);
        check("lat_rsp_result", {16'b0, rsp_result}, 32'h4040);
        check("lat_rsp_tag",    {28'b0, rsp_tag},   32'd5);
        @(negedge clk);
        check("busy_cleared",   {31'b0, busy},      32'd0);
        @(posedge clk);
        #1;

        // Subtraction and special values, back to back.
        send("sub",   2'b01, 16'h4040, 16'h3F80, 4'd6, 16'h4000);
        send("infs",  2'b00, 16'h7F80, 16'hFF80, 4'd7, 16'h7FC0);
        send("nan",   2'b00, 16'h7FC1, 16'h3F80, 4'd8, 16'h7FC0);
        wait_idle("specials");

`ifdef FPU_ACC_EN
        send("acc_clr0", 2'b11, 16'h1234, 16'h5678, 4'd1, 16'h0000);
        send("acc_add1", 2'b10, 16'h1111, 16'h3F80, 4'd2, 16'h3F80);
        send("acc_add2", 2'b10, 16'h2222, 16'h3F80, 4'd3, 16'h4000);
        wait_idle("acc_adds");
        check("acc_after_adds", {16'b0, acc}, 32'h4000);
        send("acc_clr1", 2'b11, 16'h0000, 16'h0000, 4'd4, 16'h4000);
        wait_idle("acc_clear");
        check("acc_after_clear", {16'b0, acc}, 32'h0000);
`else
        send("op10_add", 2'b10, 16'h3F80, 16'h3F80, 4'd1, 16'h4000);
        send("op11_sub", 2'b11, 16'h4000, 16'h3F80, 4'd2, 16'h3F80);
        wait_idle("noacc");
        check("acc_tied_zero", {16'b0, acc}, 32'h0000);
`endif

        // Backpressure: slot + two FIFO entries, fourth request stalls.
        rsp_ready = 1'b0;
        send("bp1", 2'b00, 16'h3F80, 16'h3F80, 4'd1, 16'h4000);
        send("bp2", 2'b00, 16'h3F80, 16'h4000, 4'd2, 16'h4040);
        send("bp3", 2'b01, 16'h4040, 16'h3F80, 4'd3, 16'h4000);
        drive_req(2'b00, 16'h3F00, 16'h3F80, 4'd4, 16'h3FC0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full_stall",  {31'b0, req_ready}, 32'd0);
            check("bp_hold_valid",  {31'b0, rsp_valid}, 32'd1);
            check("bp_hold_tag",    {28'b0, rsp_tag},   32'd1);
            check("bp_hold_result", {16'b0, rsp_result}, 32'h4000);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        acc4 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_drain_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_drain_tag",   {28'b0, rsp_tag},   32'(i + 1));
            if (req_valid && req_ready) acc4 = 1;
            @(posedge clk);
            #1;
            if (acc4) req_valid = 1'b0;
        end
        check("bp_fourth_accepted", {31'b0, acc4}, 32'd1);
        wait_idle("bp");

        // Asynchronous reset with a full FIFO and a pending response.
        rsp_ready = 1'b0;
        send("rst1", 2'b00, 16'h3F80, 16'h3F80, 4'd7, 16'h4000);
        send("rst2", 2'b00, 16'h3F80, 16'h3F80, 4'd8, 16'h4000);
        send("rst3", 2'b00, 16'h3F80, 16'h3F80, 4'd9, 16'h4000);
        check("rst_pre_full", {31'b0, req_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Streaming with random backpressure across pointer wrap-around.
        base   = rsp_count;
        rnd_en = 1;
        for (int i = 0; i < 20; i++) begin
            send("stream", 2'b00, 16'h3F80, b_tbl[i % 6], 4'(i), r_tbl[i % 6]);
        end
        rnd_en = 0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle("stream");
        check("stream_count", 32'(rsp_count - base), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_issue.md
# fpu_addsub_issue

Sequential issue/response stage that sits directly upstream of the combinational bfloat16 `Add_Sub` unit in the FPU. It buffers add/sub requests from the core in a small FIFO and drives the head entry's operands into one `Add_Sub` instance. It registers the result and returns it with its tag over a valid/ready response channel. It optionally keeps a bfloat16 accumulator register for running sums.

## Interface
- `FIFO_DEPTH`, 2: request FIFO entries; power of two, 2..8.
- `TAG_W`, 4: width of the request tag carried through to the response.

- `clk_i` in 1: single clock; all state rises on posedge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: FIFO can accept a request.
- `req_op_i` in 2: 00 add, 01 sub, 10 acc-add, 11 acc-clear.
- `req_a_i` in 16: operand A (bf16).
- `req_b_i` in 16: operand B (bf16).
- `req_tag_i` in TAG_W: request tag.
- `rsp_valid_o` out 1: response register holds a result.
- `rsp_ready_i` in 1: consumer takes the response.
- `rsp_result_o` out 16: bf16 result.
- `rsp_tag_o` out TAG_W: tag of that result.
- `acc_o` out 16: current accumulator value.
- `busy_o` out 1: FIFO non-empty OR rsp_valid_o.

## Operation
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_result_o=0x0000, rsp_tag_o=0, acc_o=0x0000, busy_o=0. FIFO pointers and count are 0.
- Push: on req_valid_i && req_ready_o. req_ready_o = !full. It is a pure function of the registered count; there is no same-cycle pass-through when full.
- Pop condition: FIFO non-empty AND (!rsp_valid_o OR rsp_ready_i). On pop, the response register loads {result, tag} and rsp_valid_o=1.
- If the consumer drains the response with no pop, rsp_valid_o goes to 0.
- Simultaneous push and pop: the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Operand mapping into `Add_Sub`:
  - `inst` = !op[0], where 1 = add and 0 = sub.
  - A = (op==10) ? acc : head.a.
  - B = head.b.
- NaN/Inf handling is entirely inside `Add_Sub`; this block does not inspect the values.
- acc-add (10): result = acc + b. acc loads the result on the same pop edge.
- acc-clear (11): the response returns the old acc value and acc loads 0x0000. The adder output is ignored.
- Back-to-back acc ops: each pop sees the acc value written by the previous pop, so no stall is needed.
- Ordering: responses leave strictly in request order. Capacity is FIFO_DEPTH + 1 outstanding requests.
- Response stability: rsp_result_o and rsp_tag_o are held constant while rsp_valid_o && !rsp_ready_i.
- Reset mid-operation: all entries and any pending response are discarded silently and acc is cleared. No response is emitted for flushed requests.

## Timing
- Request accepted at edge k:
  - With the FIFO otherwise empty and the response slot free, the entry is head during cycle k→k+1.
  - Result is registered and rsp_valid_o=1 after edge k+1, giving 1-cycle latency.
- Throughput is 1 request per cycle while rsp_ready_i=1.
- Critical path runs from the FIFO head mux through `Add_Sub` (combinational) to the response register. Nothing else is in series.
- With rsp_ready_i=0, rsp_valid_o=1 and FIFO full, req_ready_o=0 until the edge after the first response handshake.

## Configuration
- `FPU_ACC_EN` defined:
  - The accumulator register, acc-add and acc-clear are compiled in.
  - acc_o reflects the register.
- Not defined:
  - op[1] is ignored, so 10 behaves as add and 11 as sub.
  - No accumulator flops exist and acc_o is tied to 0x0000.

## Test plan
- Add: reset, then send op=00, A=0x3F80, B=0x4000, tag=5 with rsp_ready_i=1. Expect rsp_valid_o one edge after accept, with result 0x4040 and tag 5. busy_o returns to 0 the cycle after.
- Sub and specials:
  - op=01, 0x4040−0x3F80 → 0x4000.
  - op=00, 0x7F80+0xFF80 → 0x7FC0.
  - op=00, NaN 0x7FC1 + 0x3F80 → 0x7FC0.
- Backpressure with FIFO_DEPTH=2 and rsp_ready_i=0: push tags 1,2,3 with continuous valid.
  - All three are accepted (slot + 2 FIFO entries); then req_ready_o=0 and the 4th stalls.
  - rsp_result_o/tag for tag 1 are held constant.
  - Release rsp_ready_i: expect responses 1,2,3,4 in order, one per cycle.
- Accumulator (`FPU_ACC_EN`):
  - Send acc-clear, then acc-add B=0x3F80 twice back-to-back. Expect responses 0x0000 (old acc), 0x3F80, 0x4000, and acc_o=0x4000.
  - Then acc-clear returns 0x4000 and acc_o=0x0000.
  - Without the macro, op=10 with A=0x3F80, B=0x3F80 returns 0x4000.
- Reset mid-operation: fill the FIFO and hold a pending response, then pulse rst_ni low asynchronously between edges. Expect all outputs at reset values immediately, and no response emitted after reset release.
- Wrap-around: stream 20 requests with random rsp_ready_i. Expect every tag returned exactly once, in order, with correct results.
